vector_alu_sequencer: RTL and testbench
=======================================

Name: vector_alu_sequencer

Overview:
- Initiator side of the lane-ALU interface: accepts one vector instruction (3-bit opcode, two VLEN-element operand vectors, active length) via valid/ready.
- Each EXEC cycle it drives opcode/operand pairs into LANES combinational lane ALUs and registers their results and carries.
- Presents the completed result vector downstream via valid/ready.
- Sits between the vector decode/register-read stage and vector writeback.

Parameters:
N, 32, element width in bits
VLEN, 8, elements per vector register
LANES, 2, lane ALUs issued per cycle; VLEN % LANES == 0 (elaboration assertion)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  instruction offered
in_ready  output  1  sequencer can accept; high only in IDLE
in_opcode  input  3  000 add, 001 sub, 010 mul, 011 mod, 100 and, 101 div, 110 srl, 111 sll
in_vl  input  $clog2(VLEN+1)  active element count; values >VLEN clamp to VLEN
in_vec_a  input  VLEN*N  operand A, element i at bits [i*N +: N]
in_vec_b  input  VLEN*N  operand B, same packing
out_valid  output  1  result vector valid
out_ready  input  1  downstream accepts result
out_vec  output  VLEN*N  result vector
out_carry  output  VLEN  per-element carry-out (add only, else 0)
out_divzero  output  1  some active element of a mod/div had B==0

Behaviour:
- Reset (async, rst_n=0): state IDLE, in_ready=1, out_valid=0, out_vec=0, out_carry=0, out_divzero=0, idx=0. Reset mid-EXEC or mid-DONE discards the instruction; no partial output.
- FSM IDLE -> EXEC -> DONE -> IDLE. in_ready = (state==IDLE), combinational from state.
- IDLE: on in_valid&&in_ready edge, latch opcode, A, B, vl_eff=min(in_vl,VLEN); clear out_carry, out_divzero; idx=0; go EXEC.
- EXEC: each cycle lanes k=0..LANES-1 process element e=idx+k; registered into out_vec/out_carry at that edge; idx+=LANES; last EXEC cycle is when idx+LANES >= vl_eff -> DONE.
- vl_eff==0: exactly one EXEC cycle in which all elements are inactive, then DONE.
- Latency: accept edge T; EXEC cycles = max(1, ceil(vl_eff/LANES)); out_valid rises at edge T+EXEC cycles. VLEN=8, LANES=2, vl=8: out_valid high 4 edges after accept.
- Inactive element (e >= vl_eff): result = A[e], carry 0, no divzero contribution.
- Active element arithmetic (N-bit, unsigned, wraps mod 2^N):
  - add: carry = bit N of A+B.
  - sub/mul: low N bits.
  - srl/sll: shift by full B value; B>=N gives 0.
  - mod/div with B==0: result 0 (never X), out_divzero set (sticky for the instruction).
- Elements not yet processed in EXEC hold the previous instruction's values; they are only guaranteed while out_valid=1.
- DONE: out_valid=1; out_vec/out_carry/out_divzero stable while out_valid&&!out_ready. On out_ready: out_valid=0 next edge, state IDLE. No bypass: in_ready reasserts the cycle after the handshake, so the minimum instruction spacing is EXEC+2 cycles.
- in_* signals are ignored outside IDLE. out_ready is ignored outside DONE.

Decomposition:
- Package vector_pkg: opcode enum alu_op_t (ADD..SLL with the encodings above), seq_state_t {IDLE, EXEC, DONE}, default N/VLEN/LANES constants.
- Sub-module: LANES instances of the existing combinational lane ALU operations_alu, via a generate loop.
- Divide-by-zero masking (force result 0, flag) lives in the sequencer, in front of each lane.

Test Plan:
- add, vl=8, A[i]=0xFFFFFFFF, B[i]=i: out_valid after 4 EXEC cycles; out_vec[0]=0xFFFFFFFF, out_vec[1..7]=i-1, out_carry=8'hFE, out_divzero=0.
- div, vl=8, A[i]=100, B={0,5,10,0,1,2,3,4}: out_vec={0,20,10,0,100,50,33,25}, out_divzero=1, no X on any bit.
- sll, vl=3, A[i]=1, B[i]=i+30: out_vec[0..2]={0x40000000,0x80000000,0}; elements 3..7 equal A (1); EXEC lasts 2 cycles.
- vl=0, any opcode: out_vec==in_vec_a, out_carry=0, out_divzero=0; out_valid 1 cycle after accept.
- Backpressure: hold out_ready=0 for 10 cycles in DONE: outputs stable, in_ready=0 throughout. Offer a second instruction: accepted only the cycle after the out_ready handshake.
- Pulse rst_n low during the second EXEC cycle: out_valid=0, in_ready=1 immediately. A following mul with A=3, B=7 completes with all elements 21.

Source files
------------

// File: rtl/vector_alu_sequencer_pkg.sv
// rtl/vector_alu_sequencer_pkg.sv - shared types and default sizes for the vector ALU sequencer
package vector_pkg;

    localparam int DEF_N     = 32;
    localparam int DEF_VLEN  = 8;
    localparam int DEF_LANES = 2;

    typedef enum logic [2:0] {
        ADD = 3'b000,
        SUB = 3'b001,
        MUL = 3'b010,
        MOD = 3'b011,
        AND = 3'b100,
        DIV = 3'b101,
        SRL = 3'b110,
        SLL = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/vector_alu_sequencer_if.sv
// rtl/vector_alu_sequencer_if.sv - instruction and result handshakes of the vector ALU sequencer
interface vector_alu_sequencer_if #(
    parameter int N    = 32,
    parameter int VLEN = 8
);
    localparam int VLW = $clog2(VLEN + 1);

    logic                in_valid;
    logic                in_ready;
    logic [2:0]          in_opcode;
    logic [VLW-1:0]      in_vl;
    logic [VLEN*N-1:0]   in_vec_a;
    logic [VLEN*N-1:0]   in_vec_b;

    logic                out_valid;
    logic                out_ready;
    logic [VLEN*N-1:0]   out_vec;
    logic [VLEN-1:0]     out_carry;
    logic                out_divzero;

    modport master (
        output in_valid, in_opcode, in_vl, in_vec_a, in_vec_b, out_ready,
        input  in_ready, out_valid, out_vec, out_carry, out_divzero
    );

    modport slave (
        input  in_valid, in_opcode, in_vl, in_vec_a, in_vec_b, out_ready,
        output in_ready, out_valid, out_vec, out_carry, out_divzero
    );

endinterface

// File: rtl/vector_alu_sequencer_operations_alu.sv
// rtl/vector_alu_sequencer_operations_alu.sv - combinational single-element lane ALU
module operations_alu
    import vector_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  alu_op_t      op_i,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] result_o,
    output logic         carry_o
);

    logic [N:0] sum;

    assign sum = {1'b0, a_i} + {1'b0, b_i};

    // Callers must keep b_i nonzero for MOD/DIV.
    always_comb begin
        result_o = '0;
        carry_o  = 1'b0;
        unique case (op_i)
            ADD: begin
                result_o = sum[N-1:0];
                carry_o  = sum[N];
            end
            SUB: result_o = a_i - b_i;
            MUL: result_o = a_i * b_i;
            MOD: result_o = a_i % b_i;
            AND: result_o = a_i & b_i;
            DIV: result_o = a_i / b_i;
            SRL: result_o = (b_i >= N) ? '0 : (a_i >> b_i);
            SLL: result_o = (b_i >= N) ? '0 : (a_i << b_i);
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/vector_alu_sequencer.sv
// rtl/vector_alu_sequencer.sv - issues one vector instruction LANES elements per cycle into lane ALUs
module vector_alu_sequencer
    import vector_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int VLEN  = DEF_VLEN,
    parameter int LANES = DEF_LANES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    vector_alu_sequencer_if.slave bus
);

    localparam int VLW = $clog2(VLEN + 1);

    if (VLEN % LANES != 0) begin : g_bad_lanes
        $error("VLEN must be a multiple of LANES");
    end

    seq_state_t          state_q, state_d;
    alu_op_t             op_q;
    logic [VLEN*N-1:0]   a_q, b_q;
    logic [VLW-1:0]      vl_q, idx_q;
    logic [VLEN*N-1:0]   out_vec_q, out_vec_d;
    logic [VLEN-1:0]     out_carry_q, out_carry_d;
    logic                divzero_q;
    logic                last_exec;
    logic                in_ready, out_valid;

    logic [VLW-1:0]      lane_elem [LANES];
    logic [N-1:0]        lane_res  [LANES];
    logic [LANES-1:0]    lane_carry;
    logic [LANES-1:0]    lane_dz;

    assign last_exec = (int'(idx_q) + LANES) >= int'(vl_q);

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [N-1:0] a_e, b_e, b_safe, res;
        logic         carry, active, div_zero;

        assign lane_elem[k] = idx_q + VLW'(k);
        assign a_e          = a_q[int'(lane_elem[k])*N +: N];
        assign b_e          = b_q[int'(lane_elem[k])*N +: N];
        assign active       = lane_elem[k] < vl_q;
        assign div_zero     = ((op_q == MOD) || (op_q == DIV)) && (b_e == '0);
        // Steer a zero divisor away from the lane so its output is never X, then mask.
        assign b_safe       = div_zero ? N'(1) : b_e;

        operations_alu #(.N(N)) u_alu (
            .op_i     (op_q),
            .a_i      (a_e),
            .b_i      (b_safe),
            .result_o (res),
            .carry_o  (carry)
        );

        assign lane_res[k]   = !active ? a_e : (div_zero ? '0 : res);
        assign lane_carry[k] = active && carry;
        assign lane_dz[k]    = active && div_zero;
    end

    // Elements past the last issued pair are never visited, so they take A on the final cycle.
    always_comb begin
        out_vec_d   = out_vec_q;
        out_carry_d = out_carry_q;
        for (int k = 0; k < LANES; k++) begin
            out_vec_d[int'(lane_elem[k])*N +: N] = lane_res[k];
            out_carry_d[lane_elem[k]]            = lane_carry[k];
        end
        if (last_exec) begin
            for (int e = 0; e < VLEN; e++) begin
                if (e >= int'(idx_q) + LANES) begin
                    out_vec_d[e*N +: N] = a_q[e*N +: N];
                    out_carry_d[e]      = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.in_valid) state_d = EXEC;
            EXEC:    if (last_exec) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= ADD;
            a_q         <= '0;
            b_q         <= '0;
            vl_q        <= '0;
            idx_q       <= '0;
            out_vec_q   <= '0;
            out_carry_q <= '0;
            divzero_q   <= 1'b0;
        end else if (state_q == IDLE && bus.in_valid) begin
            op_q        <= alu_op_t'(bus.in_opcode);
            a_q         <= bus.in_vec_a;
            b_q         <= bus.in_vec_b;
            vl_q        <= (bus.in_vl > VLW'(VLEN)) ? VLW'(VLEN) : bus.in_vl;
            idx_q       <= '0;
            out_carry_q <= '0;
            divzero_q   <= 1'b0;
        end else if (state_q == EXEC) begin
            out_vec_q   <= out_vec_d;
            out_carry_q <= out_carry_d;
            divzero_q   <= divzero_q | (|lane_dz);
            if (!last_exec) begin
                idx_q <= idx_q + VLW'(LANES);
            end
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.out_vec     = out_vec_q;
    assign bus.out_carry   = out_carry_q;
    assign bus.out_divzero = divzero_q;

endmodule

// File: tb/tb_vector_alu_sequencer.sv
// tb/tb_vector_alu_sequencer.sv - scoreboard bench for vector_alu_sequencer
module tb_vector_alu_sequencer;
    import vector_pkg::*;

    localparam int N     = 32;
    localparam int VLEN  = 8;
    localparam int LANES = 2;
    localparam int VLW   = $clog2(VLEN + 1);

    typedef logic [VLEN*N-1:0] vec_t;
    typedef struct {
        vec_t            vec;
        logic [VLEN-1:0] carry;
        logic            dz;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vector_alu_sequencer_if #(.N(N), .VLEN(VLEN)) bus ();

    vector_alu_sequencer #(.N(N), .VLEN(VLEN), .LANES(LANES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int    checks = 0;
    int    failures = 0;
    exp_t  exp_q[$];
    exp_t  mon_e;
    string tag = "reset";

    task automatic chk(input string name, input vec_t act, input vec_t req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL %s_unexpected_result actual=1 required=0", tag);
            end else begin
                mon_e = exp_q.pop_front();
                chk({tag, "_vec"}, bus.out_vec, mon_e.vec);
                chk({tag, "_carry"}, vec_t'(bus.out_carry), vec_t'(mon_e.carry));
                chk({tag, "_divzero"}, vec_t'(bus.out_divzero), vec_t'(mon_e.dz));
            end
        end
    end

    task automatic push_exp(input vec_t v, input logic [VLEN-1:0] c, input logic d);
        exp_t e;
        e.vec = v;
        e.carry = c;
        e.dz = d;
        exp_q.push_back(e);
    endtask

    task automatic drive_in(input logic [2:0] op, input int vl, input vec_t a, input vec_t b);
        bus.in_valid  = 1'b1;
        bus.in_opcode = op;
        bus.in_vl     = VLW'(vl);
        bus.in_vec_a  = a;
        bus.in_vec_b  = b;
    endtask

    task automatic issue(input logic [2:0] op, input int vl, input vec_t a, input vec_t b);
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_in_ready"}, vec_t'(bus.in_ready), vec_t'(1));
        drive_in(op, vl, a, b);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(input int exec);
        int n = 0;
        while (bus.out_valid !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, vec_t'(n), vec_t'(exec));
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk({tag, "_valid_drop"}, vec_t'(bus.out_valid), vec_t'(0));
    endtask

    task automatic run_case(input string name, input logic [2:0] op, input int vl,
                            input vec_t a, input vec_t b, input vec_t ev,
                            input logic [VLEN-1:0] ec, input logic ed, input int exec);
        tag = name;
        push_exp(ev, ec, ed);
        issue(op, vl, a, b);
        wait_done(exec);
        release_out();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t a, b, ev, ev_add;
        logic [31:0] bdiv [8];
        logic [31:0] ediv [8];
        logic [31:0] bsrl [8];
        logic [31:0] esrl [8];

        bdiv = '{32'd0, 32'd5, 32'd10, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4};
        ediv = '{32'd0, 32'd20, 32'd10, 32'd0, 32'd100, 32'd50, 32'd33, 32'd25};
        bsrl = '{32'd0, 32'd1, 32'd31, 32'd32, 32'd33, 32'd100, 32'd4, 32'd8};
        esrl = '{32'h80000000, 32'h40000000, 32'h1, 32'h0, 32'h0, 32'h0, 32'h08000000, 32'h00800000};

        bus.in_valid = 1'b0;
        bus.in_opcode = 3'b000;
        bus.in_vl = '0;
        bus.in_vec_a = '0;
        bus.in_vec_b = '0;
        bus.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", vec_t'(bus.in_ready), vec_t'(1));
        chk("reset_out_valid", vec_t'(bus.out_valid), vec_t'(0));
        chk("reset_out_vec", bus.out_vec, '0);
        chk("reset_out_carry", vec_t'(bus.out_carry), '0);
        chk("reset_out_divzero", vec_t'(bus.out_divzero), '0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < VLEN; i++) begin
            a[i*N +: N] = 32'hFFFFFFFF;
            b[i*N +: N] = 32'(i);
            ev[i*N +: N] = (i == 0) ? 32'hFFFFFFFF : 32'(i - 1);
        end
        ev_add = ev;
        run_case("add", 3'b000, 8, a, b, ev, 8'hFE, 1'b0, 4);

        for (int i = 0; i < VLEN; i++) begin
            a[i*N +: N] = 32'(i);
            b[i*N +: N] = 32'd1;
            ev[i*N +: N] = (i == 0) ? 32'hFFFFFFFF : 32'(i - 1);
        end
        run_case("sub_clamp", 3'b001, 15, a, b, ev, 8'h00, 1'b0, 4);

        for (int i = 0; i < VLEN; i++) begin
            a[i*N +: N] = 32'd100;
            b[i*N +: N] = bdiv[i];
            ev[i*N +: N] = ediv[i];
        end
        run_case("div", 3'b101, 8, a, b, ev, 8'h00, 1'b1, 4);

        for (int i = 0; i < VLEN; i++) begin
            a[i*N +: N] = 32'(10 + i);
            b[i*N +: N] = (i < 4) ? 32'd3 : 32'd0;
        end
        ev = {32'd17, 32'd16, 32'd15, 32'd0, 32'd1, 32'd0, 32'd2, 32'd1};
        run_case("mod_vl5", 3'b011, 5, a, b, ev, 8'h00, 1'b1, 3);

        for (int i = 0; i < VLEN; i++) begin
            a[i*N +: N] = 32'd8;
            b[i*N +: N] = (i < 2) ? 32'd2 : 32'd0;
            ev[i*N +: N] = (i < 2) ? 32'd4 : 32'd8;
        end
        run_case("div_inactive_zero", 3'b101, 2, a, b, ev, 8'h00, 1'b0, 1);

        for (int i = 0; i < VLEN; i++) begin
            a[i*N +: N] = 32'd1;
            b[i*N +: N] = 32'(i + 30);
            ev[i*N +: N] = 32'd1;
        end
        ev[0*N +: N] = 32'h40000000;
        ev[1*N +: N] = 32'h80000000;
        ev[2*N +: N] = 32'h0;
        run_case("sll_vl3", 3'b111, 3, a, b, ev, 8'h00, 1'b0, 2);

        for (int i = 0; i < VLEN; i++) begin
            a[i*N +: N] = 32'h80000000;
            b[i*N +: N] = bsrl[i];
            ev[i*N +: N] = esrl[i];
        end
        run_case("srl", 3'b110, 8, a, b, ev, 8'h00, 1'b0, 4);

        for (int i = 0; i < VLEN; i++) begin
            a[i*N +: N] = 32'hFF00FF00;
            b[i*N +: N] = 32'h0F0F0F0F | 32'(i);
            ev[i*N +: N] = 32'h0F000F00;
        end
        run_case("and", 3'b100, 8, a, b, ev, 8'h00, 1'b0, 4);

        for (int i = 0; i < VLEN; i++) begin
            a[i*N +: N] = 32'(i) * 32'h11111111;
            b[i*N +: N] = 32'd0;
        end
        run_case("vl0_div", 3'b101, 0, a, b, a, 8'h00, 1'b0, 1);

        tag = "bp";
        for (int i = 0; i < VLEN; i++) begin
            a[i*N +: N] = 32'hFFFFFFFF;
            b[i*N +: N] = 32'(i);
        end
        push_exp(ev_add, 8'hFE, 1'b0);
        issue(3'b000, 8, a, b);
        wait_done(4);
        for (int i = 0; i < VLEN; i++) begin
            a[i*N +: N] = 32'd2;
            b[i*N +: N] = 32'd5;
            ev[i*N +: N] = 32'd10;
        end
        push_exp(ev, 8'h00, 1'b0);
        drive_in(3'b010, 8, a, b);
        for (int i = 0; i < 10; i++) begin
            chk("bp_out_valid_held", vec_t'(bus.out_valid), vec_t'(1));
            chk("bp_in_ready_low", vec_t'(bus.in_ready), vec_t'(0));
            chk("bp_vec_stable", bus.out_vec, ev_add);
            chk("bp_carry_stable", vec_t'(bus.out_carry), vec_t'(8'hFE));
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("bp_in_ready_after_handshake", vec_t'(bus.in_ready), vec_t'(1));
        chk("bp_out_valid_after_handshake", vec_t'(bus.out_valid), vec_t'(0));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("bp_second_accepted", vec_t'(bus.in_ready), vec_t'(0));
        tag = "bp_mul";
        wait_done(4);
        release_out();

        tag = "rst";
        for (int i = 0; i < VLEN; i++) begin
            a[i*N +: N] = 32'd9;
            b[i*N +: N] = 32'd9;
        end
        issue(3'b000, 8, a, b);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", vec_t'(bus.out_valid), vec_t'(0));
        chk("rst_in_ready", vec_t'(bus.in_ready), vec_t'(1));
        chk("rst_out_vec", bus.out_vec, '0);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < VLEN; i++) begin
            a[i*N +: N] = 32'd3;
            b[i*N +: N] = 32'd7;
            ev[i*N +: N] = 32'd21;
        end
        run_case("mul_after_rst", 3'b010, 8, a, b, ev, 8'h00, 1'b0, 4);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", vec_t'(exp_q.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
